// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command sequencer.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_ERRO  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_READY = 2'b10
    } calc_status_e;

    localparam logic [3:0] CMD_ADD  = 4'b1010;
    localparam logic [3:0] CMD_SUB  = 4'b1011;
    localparam logic [3:0] CMD_MUL  = 4'b1100;
    localparam logic [3:0] CMD_EQ   = 4'b1110;
    localparam logic [3:0] CMD_BKSP = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE       = 2'b00,
        S_WAIT_BUSY  = 2'b01,
        S_WAIT_READY = 2'b10,
        S_FAULT      = 2'b11
    } seq_state_e;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous FIFO for keypad command codes; flush empties it in one edge.
module calc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push && !reset && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Issues buffered keypad commands to the calculator datapath, paced by its status.
// Optional statistics outputs are enabled by CALC_CMD_SEQUENCER_STATS_EN.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [3:0]               key_code,
    output logic                     key_ready,
    input  logic [1:0]               calc_status,
    output logic [3:0]               cmd,
    output logic                     cmd_strobe,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fault,
    output logic                     timeout,
    output logic                     overflow,
`ifdef CALC_CMD_SEQUENCER_STATS_EN
    output logic [CNT_W-1:0]         issued_count,
    output logic [$clog2(DEPTH):0]   max_fill,
`endif
    output seq_state_e               dbg_state
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    seq_state_e              r_state;
    seq_state_e              w_next;
    logic [TW-1:0]           r_timer;
    logic [3:0]              r_cmd;
    logic                    r_strobe;
    logic                    r_timeout;
    logic                    r_overflow;
    logic                    w_issue;
    logic                    w_timer_inc;
    logic                    w_to_timeout;
    logic                    w_full;
    logic                    w_empty;
    logic [3:0]              w_head;
    logic [$clog2(DEPTH):0]  w_count;

    // Handshake: a key transfers on any edge where key_valid && key_ready.
    assign key_ready  = !w_full && (r_state != S_FAULT) && !reset;
    assign cmd        = r_cmd;
    assign cmd_strobe = r_strobe;
    assign fifo_count = w_count;
    assign fault      = (r_state == S_FAULT);
    assign timeout    = r_timeout;
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;

    calc_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(4)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (key_valid && key_ready),
        .pop   (w_issue),
        .flush (w_next == S_FAULT),
        .din   (key_code),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_next       = r_state;
        w_issue      = 1'b0;
        w_timer_inc  = 1'b0;
        w_to_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (calc_status == ST_ERRO) begin
                    w_next = S_FAULT;
                end else if (calc_status == ST_READY && !w_empty) begin
                    w_issue = 1'b1;
                    w_next  = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // Reserved status 11 counts as an acknowledgement just like BUSY.
                if (calc_status == ST_ERRO) begin
                    w_next = S_FAULT;
                end else if (calc_status != ST_READY) begin
                    w_next = S_WAIT_READY;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_next       = S_FAULT;
                    w_to_timeout = 1'b1;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            S_WAIT_READY: begin
                if (calc_status == ST_READY)     w_next = S_IDLE;
                else if (calc_status == ST_ERRO) w_next = S_FAULT;
            end
            default: w_next = S_FAULT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_cmd      <= '0;
            r_strobe   <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_strobe <= w_issue;
            if (w_issue) begin
                r_cmd   <= w_head;
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_to_timeout)             r_timeout  <= 1'b1;
            if (key_valid && !key_ready)  r_overflow <= 1'b1;
        end
    end

`ifdef CALC_CMD_SEQUENCER_STATS_EN
    logic [CNT_W-1:0]        r_issued;
    logic [$clog2(DEPTH):0]  r_max_fill;

    assign issued_count = r_issued;
    assign max_fill     = r_max_fill;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_issued   <= '0;
            r_max_fill <= '0;
        end else begin
            if (w_issue && (r_issued != '1)) r_issued <= r_issued + 1'b1;
            if (w_count > r_max_fill)        r_max_fill <= w_count;
        end
    end
`endif

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Randomized scoreboard bench for calc_cmd_sequencer with a simple datapath model.
`timescale 1ns/1ps
module tb_calc_cmd_sequencer;
    import calc_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 8;
    localparam int CW      = $clog2(DEPTH) + 1;

    // ---------------- clock / reset / DUT ----------------
    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           key_valid = 1'b0;
    logic [3:0]     key_code = 4'd0;
    logic           key_ready;
    logic [1:0]     calc_status;
    logic [3:0]     cmd;
    logic           cmd_strobe;
    logic [CW-1:0]  fifo_count;
    logic           fault;
    logic           timeout;
    logic           overflow;
    seq_state_e     dbg_state;
`ifdef CALC_CMD_SEQUENCER_STATS_EN
    logic [CNT_W-1:0] issued_count;
    logic [CW-1:0]    max_fill;
`endif

    always #5 clock = ~clock;

    calc_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .calc_status  (calc_status),
        .cmd          (cmd),
        .cmd_strobe   (cmd_strobe),
        .fifo_count   (fifo_count),
        .fault        (fault),
        .timeout      (timeout),
        .overflow     (overflow),
`ifdef CALC_CMD_SEQUENCER_STATS_EN
        .issued_count (issued_count),
        .max_fill     (max_fill),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state / reference model ----------------
    logic [3:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_strobes = 0;
    int cyc = 0;
    int last_strobe_cyc = -100;
    logic [1:0] prev_status = 2'b01;
    bit model_fault = 0;
    bit model_ovf = 0;
    int model_accepted = 0;
    int model_max_fill = 0;

    // datapath model controls (written only by the main thread)
    int dp_mode = 0;           // 0: hold dp_force, 1: auto BUSY/READY responder
    logic [1:0] dp_force = ST_BUSY;
    int dp_lat = 0;            // 0 selects a random BUSY time per command
    int busy_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // datapath model: sole driver of calc_status, updates 1ns after each edge
    initial begin
        calc_status = ST_BUSY;
        forever begin
            @(posedge clock);
            #1;
            if (dp_mode == 0) begin
                calc_status = dp_force;
            end else if (cmd_strobe) begin
                calc_status = ST_BUSY;
                busy_left = (dp_lat == 0) ? int'($urandom_range(1, 5)) : dp_lat;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) calc_status = ST_READY;
            end else begin
                calc_status = ST_READY;
            end
        end
    end

    // monitor: every strobe must match the oldest accepted key
    always @(negedge clock) begin
        cyc++;
        if (!reset && cmd_strobe) begin
            n_strobes++;
            chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("cmd_order", 32'(cmd), 32'(exp_q.pop_front()));
            chk("issue_while_ready", 32'(prev_status), 32'(ST_READY));
            chk("strobe_spacing_ok", 32'(cyc - last_strobe_cyc >= 3), 32'd1);
            last_strobe_cyc = cyc;
        end
        prev_status = calc_status;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    // Offers one key for one edge; acceptance is predicted from model occupancy.
    task automatic send_key(input logic [3:0] code);
        bit acc;
        key_valid = 1'b1;
        key_code  = code;
        sample();
        chk("fifo_count_model", 32'(fifo_count), 32'(exp_q.size()));
        acc = (exp_q.size() < DEPTH) && !model_fault;
        chk("key_ready", 32'(key_ready), 32'(acc));
        if (acc) begin
            exp_q.push_back(code);
            model_accepted++;
            if (exp_q.size() > model_max_fill) model_max_fill = exp_q.size();
        end else begin
            model_ovf = 1;
        end
        @(posedge clock);
        #2;
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key_valid = 1'b0;
        sample();
        chk("key_ready_in_reset", 32'(key_ready), 32'd0);
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        model_fault = 0;
        model_ovf = 0;
        model_accepted = 0;
        model_max_fill = 0;
        sample();
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_strobe", 32'(cmd_strobe), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            sample();
            if (exp_q.size() == 0 && dbg_state == S_IDLE && calc_status == ST_READY) begin
                done = 1;
                break;
            end
        end
        chk("drain_in_budget", 32'(done), 32'd1);
        chk("drain_count", 32'(fifo_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s0;
        logic [3:0] k;
        logic [3:0] seq2[5];

        tick(2);
        dp_mode = 0;
        dp_force = ST_READY;
        tick(1);
        do_reset();

        // 1: single key, one-cycle issue latency through the FIFO
        tick(1);
        k = 4'd5;
        s0 = n_strobes;
        send_key(k);
        sample();
        chk("t1_count_after_push", 32'(fifo_count), 32'd1);
        chk("t1_no_strobe_yet", 32'(cmd_strobe), 32'd0);
        sample();
        chk("t1_strobe", 32'(cmd_strobe), 32'd1);
        chk("t1_cmd", 32'(cmd), 32'd5);
        chk("t1_count_after_pop", 32'(fifo_count), 32'd0);
        tick(1);
        dp_force = ST_BUSY;
        tick(3);
        dp_force = ST_READY;
        wait_idle(20);
        chk("t1_back_idle", 32'(dbg_state), 32'(S_IDLE));
        chk("t1_strobes", 32'(n_strobes - s0), 32'd1);

        // 2: back-to-back operator sequence with a 4-cycle BUSY datapath
        tick(1);
        dp_lat = 4;
        dp_mode = 1;
        seq2[0] = 4'd1; seq2[1] = 4'd2; seq2[2] = CMD_ADD; seq2[3] = 4'd3; seq2[4] = CMD_EQ;
        s0 = n_strobes;
        for (int i = 0; i < 5; i++) send_key(seq2[i]);
        wait_idle(200);
        chk("t2_strobes", 32'(n_strobes - s0), 32'd5);

        // 3: fill while BUSY, overflow on fifth key, then drain in order
        tick(1);
        dp_mode = 0;
        dp_force = ST_BUSY;
        tick(2);
        s0 = n_strobes;
        for (int i = 0; i < 5; i++) send_key(4'($urandom_range(0, 15)));
        sample();
        chk("t3_overflow", 32'(overflow), 32'(model_ovf));
        chk("t3_count_full", 32'(fifo_count), 32'(DEPTH));
        chk("t3_key_ready_low", 32'(key_ready), 32'd0);
        tick(1);
        dp_lat = 0;
        dp_mode = 1;
        wait_idle(200);
        chk("t3_strobes", 32'(n_strobes - s0), 32'(DEPTH));
        chk("t3_overflow_sticky", 32'(overflow), 32'd1);

        // randomized traffic: random keys, gaps and BUSY times
        tick(1);
        for (int i = 0; i < 24; i++) begin
            send_key(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) tick(int'($urandom_range(1, 3)));
        end
        wait_idle(400);
        chk("rand_no_fault", 32'(fault), 32'd0);

        // 4: acknowledge timeout with status stuck at READY
        tick(1);
        dp_mode = 0;
        dp_force = ST_READY;
        tick(1);
        do_reset();
        tick(1);
        send_key(4'($urandom_range(0, 15)));
        begin
            bit seen = 0;
            for (int i = 0; i < 10; i++) begin
                sample();
                if (cmd_strobe) begin
                    seen = 1;
                    break;
                end
            end
            chk("t4_strobe_seen", 32'(seen), 32'd1);
        end
        for (int i = 1; i <= TIMEOUT; i++) begin
            sample();
            if (i == TIMEOUT - 1) chk("t4_no_fault_early", 32'(fault), 32'd0);
            if (i == TIMEOUT) begin
                chk("t4_fault", 32'(fault), 32'd1);
                chk("t4_timeout", 32'(timeout), 32'd1);
                chk("t4_count", 32'(fifo_count), 32'd0);
                chk("t4_key_ready", 32'(key_ready), 32'd0);
                chk("t4_state", 32'(dbg_state), 32'(S_FAULT));
            end
        end
        model_fault = 1;

        // 5: datapath ERROR while WAIT_READY with two keys queued
        tick(1);
        dp_lat = 20;
        dp_mode = 1;
        tick(1);
        do_reset();
        tick(1);
        for (int i = 0; i < 3; i++) send_key(4'($urandom_range(0, 15)));
        sample();
        chk("t5_wait_ready", 32'(dbg_state), 32'(S_WAIT_READY));
        chk("t5_queued", 32'(fifo_count), 32'd2);
        tick(1);
        dp_mode = 0;
        dp_force = ST_ERRO;
        tick(2);
        sample();
        chk("t5_fault", 32'(fault), 32'd1);
        chk("t5_timeout_clear", 32'(timeout), 32'd0);
        chk("t5_flushed", 32'(fifo_count), 32'd0);
        chk("t5_key_ready", 32'(key_ready), 32'd0);
        exp_q.delete();
        model_fault = 1;
        s0 = n_strobes;
        tick(1);
        send_key(4'($urandom_range(0, 15)));
        tick(10);
        sample();
        chk("t5_no_strobes", 32'(n_strobes - s0), 32'd0);
        chk("t5_overflow_in_fault", 32'(overflow), 32'(model_ovf));
        tick(1);
        dp_force = ST_READY;
        tick(1);
        do_reset();

`ifdef CALC_CMD_SEQUENCER_STATS_EN
        // 6: statistics after a peak fill of three
        tick(1);
        dp_force = ST_BUSY;
        tick(2);
        for (int i = 0; i < 3; i++) send_key(4'($urandom_range(0, 15)));
        sample();
        chk("t6_fill", 32'(fifo_count), 32'd3);
        tick(1);
        dp_lat = 0;
        dp_mode = 1;
        wait_idle(100);
        chk("t6_issued", 32'(issued_count), 32'(model_accepted));
        chk("t6_max_fill", 32'(max_fill), 32'(model_max_fill));
`endif

        tick(2);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
